// File: rtl/sm3_msg_expand.sv
// SM3 message-expansion scheduler: loads one 512-bit block and streams
// (W_j, W'_j) for j = 0..63 over a valid/ready handshake, one pair per transfer.

module sm3_rol (
    input  logic [31:0] din,
    input  logic [4:0]  num,
    output logic [31:0] dout
);

    logic [63:0] dbl_s;

    // Rotate-left by num via a doubled word shifted and upper half taken
    always_comb begin
        dbl_s = {din, din} << num;
        dout  = dbl_s[63:32];
    end

endmodule

module sm3_msg_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] din,
    input  logic         ready,
    output logic         busy,
    output logic         wj_valid,
    output logic [31:0]  wj,
    output logic [31:0]  wpj,
    output logic [6:0]   j,
    output logic         done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] win_r [0:15];
    logic [6:0]  cnt_r;
    logic        done_r;
    logic        load_s;
    logic        xfer_s;
    logic        last_s;

    logic [31:0] w13_rol15_s;
    logic [31:0] w3_rol7_s;
    logic [31:0] x_s;
    logic [31:0] x_rol15_s;
    logic [31:0] x_rol23_s;
    logic [31:0] wnew_s;

    sm3_rol u_rol_w13 (.din(win_r[13]), .num(5'd15), .dout(w13_rol15_s));
    sm3_rol u_rol_w3  (.din(win_r[3]),  .num(5'd7),  .dout(w3_rol7_s));
    sm3_rol u_rol_x15 (.din(x_s),       .num(5'd15), .dout(x_rol15_s));
    sm3_rol u_rol_x23 (.din(x_s),       .num(5'd23), .dout(x_rol23_s));

    // Next window word W_{j+16}: P1 applied to the first XOR group, then mixed in
    always_comb begin
        x_s    = win_r[0] ^ win_r[7] ^ w13_rol15_s;
        wnew_s = x_s ^ x_rol15_s ^ x_rol23_s ^ w3_rol7_s ^ win_r[10];
    end

    // Next-state and handshake decode
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        xfer_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                xfer_s = ready;
                last_s = ready && (cnt_r == 7'd63);
                if (last_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RUN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sliding window: parallel load on start, shift-in of W_{j+16} per transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                win_r[k] <= 32'd0;
            end
        end else if (load_s) begin
            for (int k = 0; k < 16; k++) begin
                win_r[k] <= din[511 - 32*k -: 32];
            end
        end else if (xfer_s) begin
            for (int k = 0; k < 15; k++) begin
                win_r[k] <= win_r[k + 1];
            end
            win_r[15] <= wnew_s;
        end
    end

    // Index counter returns to 0 after the last pair so j never leaves 0..63
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 7'd0;
        end else if (load_s || last_s) begin
            cnt_r <= 7'd0;
        end else if (xfer_s) begin
            cnt_r <= cnt_r + 7'd1;
        end
    end

    // One-cycle completion pulse after the final transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
        end
    end

    // Outputs come from registered state only; data is zeroed outside RUN
    always_comb begin
        busy     = (state_r == S_RUN);
        wj_valid = (state_r == S_RUN);
        j        = cnt_r;
        done     = done_r;
        if (state_r == S_RUN) begin
            wj  = win_r[0];
            wpj = win_r[0] ^ win_r[4];
        end else begin
            wj  = 32'd0;
            wpj = 32'd0;
        end
    end

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Randomized self-checking bench for sm3_msg_expand against a direct
// W_0..W_67 expansion model computed from the SM3 recurrence.

module tb_sm3_msg_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] din;
    logic         ready;
    logic         busy;
    logic         wj_valid;
    logic [31:0]  wj;
    logic [31:0]  wpj;
    logic [6:0]   j;
    logic         done;

    int errs;
    int checks;

    logic [31:0] wm      [0:67];
    logic [31:0] got_wj  [0:63];
    logic [31:0] got_wpj [0:63];

    sm3_msg_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (din),
        .ready    (ready),
        .busy     (busy),
        .wj_valid (wj_valid),
        .wj       (wj),
        .wpj      (wpj),
        .j        (j),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    function automatic logic [511:0] rblk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Reference expansion straight from the SM3 definition
    task automatic expand(input logic [511:0] b);
        for (int i = 0; i < 16; i++) wm[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++)
            wm[i] = p1(wm[i-16] ^ wm[i-9] ^ rl(wm[i-3], 15)) ^ rl(wm[i-13], 7) ^ wm[i-6];
    endtask

    task automatic start_block(input logic [511:0] b);
        din   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din   = rblk();
    endtask

    // Streams block b until stop_at pairs are taken; optional ignored start and back-to-back load
    task automatic stream(input logic [511:0] b, input int rpct, input int ign_at,
                          input int stop_at, input bit b2b, input logic [511:0] nb);
        int k;
        int cyc;
        bit r;
        expand(b);
        k   = 0;
        cyc = 0;
        while (k < stop_at) begin
            if (cyc >= 3000) begin
                chk("timeout", 64'(k), 64'(stop_at));
                return;
            end
            chk("valid", 64'(wj_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_mid", 64'(done), 64'd0);
            chk("j", 64'(j), 64'(k));
            chk("wj", 64'(wj), 64'(wm[k]));
            chk("wpj", 64'(wpj), 64'(wm[k] ^ wm[k+4]));
            got_wj[k]  = wj;
            got_wpj[k] = wpj;
            r     = ($urandom_range(99) < rpct);
            ready = r;
            if (k == ign_at) begin
                start = 1'b1;
                din   = rblk();
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (r) k++;
            cyc++;
        end
        start = 1'b0;
        if (stop_at == 64) begin
            chk("done_pulse", 64'(done), 64'd1);
            chk("valid_end", 64'(wj_valid), 64'd0);
            chk("busy_end", 64'(busy), 64'd0);
            chk("j_end", 64'(j), 64'd0);
            ready = 1'b0;
            if (b2b) begin
                din   = nb;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            din   = rblk();
            chk("done_once", 64'(done), 64'd0);
        end
    endtask

    logic [511:0] abc;
    logic [511:0] blk;
    logic [511:0] blk2;

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        din    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(wj_valid), 64'd0);
        chk("rst_wj", 64'(wj), 64'd0);
        chk("rst_wpj", 64'(wpj), 64'd0);
        chk("rst_j", 64'(j), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: standard "abc" block
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        start_block(abc);
        stream(abc, 100, -1, 64, 1'b0, '0);
        chk("abc_wj0", 64'(got_wj[0]), 64'h61626380);
        chk("abc_wpj0", 64'(got_wpj[0]), 64'h61626380);
        chk("abc_wpj12", 64'(got_wpj[12]), 64'h9092e200);
        chk("abc_wj16", 64'(got_wj[16]), 64'h9092e200);
        chk("abc_wj18", 64'(got_wj[18]), 64'h000c0606);
        chk("abc_wj19", 64'(got_wj[19]), 64'h719c70ed);

        // 2: random block with ~50% backpressure
        blk = rblk();
        start_block(blk);
        stream(blk, 50, -1, 64, 1'b0, '0);

        // 3: start at j = 10 is ignored
        blk = rblk();
        start_block(blk);
        stream(blk, 100, 10, 64, 1'b0, '0);

        // 4: back-to-back blocks, new start in the done cycle
        blk  = rblk();
        blk2 = rblk();
        start_block(blk);
        stream(blk, 70, -1, 64, 1'b1, blk2);
        stream(blk2, 100, -1, 64, 1'b0, '0);

        // 5: reset at j = 37 while stalled
        blk = rblk();
        start_block(blk);
        stream(blk, 60, -1, 37, 1'b0, '0);
        ready = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(wj_valid), 64'd0);
        chk("mrst_wj", 64'(wj), 64'd0);
        chk("mrst_wpj", 64'(wpj), 64'd0);
        chk("mrst_j", 64'(j), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("mrst_done2", 64'(done), 64'd0);
        blk = rblk();
        start_block(blk);
        stream(blk, 80, -1, 64, 1'b0, '0);

        // 6: all-ones block
        blk = {512{1'b1}};
        start_block(blk);
        stream(blk, 100, -1, 64, 1'b0, '0);
        chk("ones_wj16", 64'(got_wj[16]), 64'hffffffff);
        @(posedge clk); #1;
        chk("ones_idle_valid", 64'(wj_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
